// File: rtl/ext_pipe_pkg.sv
// ext_pipe_pkg
// Shared constants for the operand extender: operation-select codes for the
// immediate and load paths, the mode field width, and the width of the raw
// field carried from the lane selector into the extend stage.
//
// Optional feature macro: EXT_PIPE_LWLR_EN
//   When defined, the mode field grows to 4 bits and the unaligned word
//   loads LWL (8) and LWR (9) exist. Otherwise the mode field is 3 bits and
//   every code is a defined operation.
package ext_pipe_pkg;

`ifdef EXT_PIPE_LWLR_EN
  localparam int MODE_W = 4;
`else
  localparam int MODE_W = 3;
`endif

  // The widest field any mode selects is a 32-bit word, so S1 only needs
  // to carry 32 raw bits regardless of the datapath width.
  localparam int RAW_W = 32;

  // Operation-select codes, shared by the ID-stage immediate generator and
  // the load write-back path.
  typedef enum logic [MODE_W-1:0] {
    EXT_SEL_ZERO = MODE_W'(0),
    EXT_SEL_SIGN = MODE_W'(1),
    EXT_SEL_LUI  = MODE_W'(2),
    EXT_LB       = MODE_W'(3),
    EXT_LBU      = MODE_W'(4),
    EXT_LH       = MODE_W'(5),
    EXT_LHU      = MODE_W'(6),
    EXT_LW       = MODE_W'(7)
`ifdef EXT_PIPE_LWLR_EN
    ,
    EXT_LWL      = MODE_W'(8),
    EXT_LWR      = MODE_W'(9)
`endif
  } ext_mode_e;

endpackage

// File: rtl/ext_lane_select.sv
// ext_lane_select
// Combinational front half of the extender. Picks the byte lanes a load
// refers to (little-endian, lane k = data[8k+7:8k]), checks alignment,
// and for LWL/LWR merges the selected memory bytes into the old rt value.
// The selected field is returned right-justified and zero-padded; sign or
// zero extension happens later in the pipeline.
//
// Ports:
//   mode     operation select
//   data     raw memory word, or immediate in the low IMM_W bits
//   addr_lo  byte offset of the load
//   merge    old rt value (LWL/LWR only)
//   raw      right-justified selected field
//   err      misaligned access or illegal mode
//
// Optional feature macro: EXT_PIPE_LWLR_EN (adds LWL/LWR merging).
module ext_lane_select
  import ext_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int AW     = $clog2(DATA_W/8)
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] data,
  input  logic [AW-1:0]     addr_lo,
  input  logic [DATA_W-1:0] merge,
  output logic [RAW_W-1:0]  raw,
  output logic              err
);

  logic [DATA_W-1:0] lane_shift;
  logic [1:0]        word_off;
  logic              unused_merge;

  // merge is only consumed by LWL/LWR, and only its low word at that.
  assign unused_merge = ^merge;

`ifdef EXT_PIPE_LWLR_EN
  logic [AW-1:0]     word_base;
  logic [DATA_W-1:0] word_shift;
  logic [31:0]       word;

  // LWL/LWR work on the aligned word containing the addressed byte; the
  // offset inside that word decides how many bytes are merged.
  always_comb begin
    word_base  = addr_lo & ~AW'(3);
    word_shift = data >> {word_base, 3'b000};
    word       = word_shift[31:0];
  end
`endif

  // Shifting the addressed lane down to bit 0 lets byte, halfword and word
  // loads all take their field from the bottom of the same shifted word.
  always_comb begin
    lane_shift = data >> {addr_lo, 3'b000};
    word_off   = addr_lo[1:0];
    raw        = '0;
    err        = 1'b0;
    case (mode)
      EXT_SEL_ZERO, EXT_SEL_SIGN, EXT_SEL_LUI: raw = RAW_W'(data[IMM_W-1:0]);
      EXT_LB, EXT_LBU:                         raw = RAW_W'(lane_shift[7:0]);
      EXT_LH, EXT_LHU: begin
        if (addr_lo[0]) err = 1'b1;
        else            raw = RAW_W'(lane_shift[15:0]);
      end
      EXT_LW: begin
        if (word_off != 2'd0) err = 1'b1;
        else                  raw = lane_shift[31:0];
      end
`ifdef EXT_PIPE_LWLR_EN
      // LWL: memory lanes 0..a land in result bytes 3-a..3, the rest of
      // the result keeps the low bytes of the old rt value.
      EXT_LWL: raw = (word << {~word_off, 3'b000}) |
                     (merge[31:0] & (32'hFFFF_FFFF >> ({1'b0, word_off, 3'b000} + 6'd8)));
      // LWR: memory lanes a..3 land in result bytes 0..3-a, the top a
      // bytes keep the old rt value.
      EXT_LWR: raw = (word >> {word_off, 3'b000}) |
                     (merge[31:0] & ~(32'hFFFF_FFFF >> {word_off, 3'b000}));
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe
// Two-stage pipelined operand extender shared by the decode immediate path
// and the load write-back path. S1 registers the lane-selected raw field,
// mode, error flag and tag; S2 registers the zero/sign/LUI-extended result.
// Valid/ready handshake on both sides; a stage only updates when it loads.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_mode               operation select (ext_mode_e codes)
//   in_data               raw memory word or immediate (low IMM_W bits)
//   in_addr_lo            byte offset of a load
//   in_merge              old rt value for LWL/LWR
//   in_tag                sideband, passed through
//   out_valid / out_ready output handshake
//   out_data              extended result, 0 when out_err
//   out_err               misaligned load or illegal mode
//   out_tag               sideband of the result
//
// Optional feature macro: EXT_PIPE_LWLR_EN (4-bit mode, LWL/LWR).
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MODE_W-1:0]           in_mode,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(DATA_W/8)-1:0] in_addr_lo,
  input  logic [DATA_W-1:0]           in_merge,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_err,
  output logic [TAG_W-1:0]            out_tag
);

  localparam int AW = $clog2(DATA_W/8);

  logic              s1_valid;
  logic [RAW_W-1:0]  s1_raw;
  logic [MODE_W-1:0] s1_mode;
  logic              s1_err;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_valid;

  logic              s1_load;
  logic              s2_load;
  logic [RAW_W-1:0]  sel_raw;
  logic              sel_err;
  logic [DATA_W-1:0] ext_data;
  logic [31:0]       lui_word;

  ext_lane_select #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .AW     (AW)
  ) u_lane_select (
    .mode    (in_mode),
    .data    (in_data),
    .addr_lo (in_addr_lo),
    .merge   (in_merge),
    .raw     (sel_raw),
    .err     (sel_err)
  );

  // Each stage loads when it is empty or the stage after it is loading, so
  // a full pipe with a draining consumer shifts all beats in one cycle.
  // in_ready is derived from stage state only, never from in_valid.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = rst_n && s1_load;
  assign out_valid = s2_valid;

  // Extend stage: turns the right-justified raw field into a DATA_W result.
  // LUI shifts the immediate into the upper half of a 32-bit word and then
  // treats that word like a signed word load.
  always_comb begin
    lui_word = s1_raw << 16;
    ext_data = '0;
    case (s1_mode)
      EXT_SEL_ZERO: ext_data = DATA_W'(s1_raw[IMM_W-1:0]);
      EXT_SEL_SIGN: ext_data = DATA_W'($signed(s1_raw[IMM_W-1:0]));
      EXT_SEL_LUI:  ext_data = DATA_W'($signed(lui_word));
      EXT_LB:       ext_data = DATA_W'($signed(s1_raw[7:0]));
      EXT_LBU:      ext_data = DATA_W'(s1_raw[7:0]);
      EXT_LH:       ext_data = DATA_W'($signed(s1_raw[15:0]));
      EXT_LHU:      ext_data = DATA_W'(s1_raw[15:0]);
      EXT_LW:       ext_data = DATA_W'($signed(s1_raw));
`ifdef EXT_PIPE_LWLR_EN
      EXT_LWL:      ext_data = DATA_W'($signed(s1_raw));
      EXT_LWR:      ext_data = DATA_W'($signed(s1_raw));
`endif
      default:      ext_data = '0;
    endcase
    if (s1_err) ext_data = '0;
  end

  // S1 valid bit: cleared by reset, otherwise follows the input whenever
  // the stage is free to load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
    end
  end

  // S1 payload: captured only on an actual input transfer; no reset needed
  // because it is never observed while s1_valid is low.
  always_ff @(posedge clk) begin
    if (rst_n && s1_load && in_valid) begin
      s1_raw  <= sel_raw;
      s1_mode <= in_mode;
      s1_err  <= sel_err;
      s1_tag  <= in_tag;
    end
  end

  // S2: the output registers. They hold while the consumer stalls and only
  // take new payload when a valid beat moves up from S1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
      out_tag  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= ext_data;
        out_err  <= s1_err;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule
